// File: rtl/board_io_pkg.sv
// Shared definitions for the board-level I/O controller: LED display modes,
// the width of the FP exception flag group, and the bit positions of the
// sticky error bits as they appear on the status display.
package board_io_pkg;

  // LED display modes selected by the VIO "mode" field
  typedef enum logic [1:0] {
    LED_MODE_DATA   = 2'd0,
    LED_MODE_STATUS = 2'd1,
    LED_MODE_PWM    = 2'd2,
    LED_MODE_TEST   = 2'd3
  } led_mode_e;

  // Number of FP exception flags reported by the processor
  localparam int FP_FLAG_W = 5;

  // Sticky error bits: integer and FP unrecognised-instruction
  localparam int ERR_W   = 2;
  localparam int ERR_INT = 0;
  localparam int ERR_FP  = 1;

  // Status display word: flags in the low bits, error bits just above them
  localparam int STATUS_W = ERR_W + FP_FLAG_W;

  // Packs the sticky state into the layout shown on the LEDs in status mode
  function automatic logic [STATUS_W-1:0] pack_status(
    input logic [ERR_W-1:0]     err,
    input logic [FP_FLAG_W-1:0] flags
  );
    return {err, flags};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-channel button debouncer.
// The raw pin is brought into the clock domain by a two-flop synchronizer.
// A counter measures how long the synchronized value has disagreed with the
// debounced level; only after DEBOUNCE_CYCLES consecutive disagreeing cycles
// does the level follow. Any agreement in between restarts the count, so a
// glitch shorter than DEBOUNCE_CYCLES is ignored. A one-cycle press pulse
// accompanies every rising edge of the debounced level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync_q;
  logic [CNT_W-1:0] stable_cnt;

  // Two-flop synchronizer for the asynchronous button pin
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= btn_raw;
      sync_q    <= sync_meta;
    end
  end

  // Disagreement counter; flips the level once the new value has held long enough
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable_cnt <= '0;
      btn_level  <= 1'b0;
      btn_press  <= 1'b0;
    end else begin
      btn_press <= 1'b0;
      if (sync_q != btn_level) begin
        if (stable_cnt == CNT_MAX) begin
          btn_level  <= sync_q;
          btn_press  <= sync_q;
          stable_cnt <= '0;
        end else begin
          stable_cnt <= stable_cnt + CNT_W'(1);
        end
      end else begin
        stable_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/board_io_ctrl.sv
// Board-level I/O controller for the FPGA top wrapper.
// Collects the board buttons, the processor status outputs and the VIO
// controls and turns them into:
//   - debounced button levels and press pulses (one debouncer per channel),
//   - a stretched reset request to the processor (button 0 or VIO request),
//   - a heartbeat that stops while the processor is being reset,
//   - sticky capture of error pulses and FP exception flags,
//   - a registered LED display whose lower bits are chosen by "mode" and
//     whose top bit always shows the heartbeat.
module board_io_ctrl
  import board_io_pkg::*;
#(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HB_HALF_PERIOD  = 50000000,
  parameter int RST_STRETCH     = 16,
  parameter int NUM_LED         = 8,
  parameter int DATA_W          = 32,
  parameter int PWM_W           = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_BTN-1:0]   btn_raw,
  output logic [NUM_BTN-1:0]   btn_level,
  output logic [NUM_BTN-1:0]   btn_press,
  input  logic                 soft_reset_req,
  output logic                 sys_reset_req,
  input  logic [1:0]           mode,
  input  logic [PWM_W-1:0]     brightness,
  input  logic                 wb_valid,
  input  logic [DATA_W-1:0]    wb_data,
  input  logic [FP_FLAG_W-1:0] fp_flags,
  input  logic                 err_int,
  input  logic                 err_fp,
  input  logic                 err_clear,
  output logic [NUM_LED-1:0]   led
);

  // The top LED is reserved for the heartbeat; the rest carry display data
  localparam int LED_DATA_W = NUM_LED - 1;

  localparam int HB_W = (HB_HALF_PERIOD > 2) ? $clog2(HB_HALF_PERIOD) : 1;
  localparam logic [HB_W-1:0] HB_MAX = HB_W'(HB_HALF_PERIOD - 1);

  localparam int ST_W = $clog2(RST_STRETCH + 1);
  localparam logic [ST_W-1:0] ST_LOAD = ST_W'(RST_STRETCH);
  localparam logic [ST_W-1:0] ST_ONE  = ST_W'(1);

  logic                  rst_trigger;
  logic [ST_W-1:0]       stretch_cnt;

  logic [HB_W-1:0]       hb_cnt;
  logic                  hb;

  logic [LED_DATA_W-1:0] wb_q;

  logic [ERR_W-1:0]      err_set;
  logic [ERR_W-1:0]      err_q;
  logic [FP_FLAG_W-1:0]  flag_q;

  logic [PWM_W-1:0]      pwm_cnt;
  logic                  pwm_on;

  logic [LED_DATA_W-1:0] led_low;

  // ---------------------------------------------------------------------------
  // Button debounce: one independent debouncer per channel
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk       (clk),
      .reset     (reset),
      .btn_raw   (btn_raw[i]),
      .btn_level (btn_level[i]),
      .btn_press (btn_press[i])
    );
  end

  // ---------------------------------------------------------------------------
  // Reset stretch
  // Button 0 and the VIO request both start a reset; coincident triggers are
  // just one trigger. The counter holds the remaining high cycles, and a
  // retrigger while already active reloads it to the full length.
  // ---------------------------------------------------------------------------
  assign rst_trigger = btn_press[0] | soft_reset_req;

  // Reload on a trigger, otherwise count down the remaining request cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stretch_cnt   <= '0;
      sys_reset_req <= 1'b0;
    end else if (rst_trigger) begin
      stretch_cnt   <= ST_LOAD;
      sys_reset_req <= 1'b1;
    end else if (stretch_cnt > ST_ONE) begin
      stretch_cnt   <= stretch_cnt - ST_ONE;
      sys_reset_req <= 1'b1;
    end else begin
      stretch_cnt   <= '0;
      sys_reset_req <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Heartbeat
  // Toggles every HB_HALF_PERIOD cycles. Held at zero while the processor is
  // in reset so the board visibly "stops breathing" during a reset.
  // ---------------------------------------------------------------------------

  // Half-period counter with toggle on wrap, frozen at zero during reset requests
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hb_cnt <= '0;
      hb     <= 1'b0;
    end else if (sys_reset_req) begin
      hb_cnt <= '0;
      hb     <= 1'b0;
    end else if (hb_cnt == HB_MAX) begin
      hb_cnt <= '0;
      hb     <= ~hb;
    end else begin
      hb_cnt <= hb_cnt + HB_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Writeback data capture
  // Only the bits that can ever reach the LEDs are kept.
  // ---------------------------------------------------------------------------

  // Latch the displayable part of the writeback word on each valid beat
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_q <= '0;
    end else if (wb_valid) begin
      wb_q <= wb_data[LED_DATA_W-1:0];
    end
  end

  // The upper writeback bits are intentionally not displayed
  if (DATA_W > LED_DATA_W) begin : g_wb_hi
    logic unused_wb_hi;
    assign unused_wb_hi = ^wb_data[DATA_W-1:LED_DATA_W];
  end

  // ---------------------------------------------------------------------------
  // Sticky error and FP flag capture
  // A set pulse arriving together with err_clear survives the clear, so no
  // event is ever lost by a clear that happens to land on it.
  // ---------------------------------------------------------------------------

  // Map the individual error pulses onto their sticky bit positions
  always_comb begin
    err_set          = '0;
    err_set[ERR_INT] = err_int;
    err_set[ERR_FP]  = err_fp;
  end

  // Accumulate error and flag pulses until cleared; new sets win over a clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q  <= '0;
      flag_q <= '0;
    end else if (err_clear) begin
      err_q  <= err_set;
      flag_q <= fp_flags;
    end else begin
      err_q  <= err_q | err_set;
      flag_q <= flag_q | fp_flags;
    end
  end

  // ---------------------------------------------------------------------------
  // PWM dimming
  // Free-running counter; brightness is the number of "on" slots per period,
  // except that the all-ones setting means permanently on.
  // ---------------------------------------------------------------------------

  // Free-running PWM slot counter, wrapping naturally after all-ones
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
    end
  end

  assign pwm_on = (brightness == {PWM_W{1'b1}}) || (pwm_cnt < brightness);

  // ---------------------------------------------------------------------------
  // LED display
  // ---------------------------------------------------------------------------

  // Select what the lower LEDs show for the current display mode
  always_comb begin
    led_low = '0;
    case (led_mode_e'(mode))
      LED_MODE_DATA:   led_low = wb_q;
      LED_MODE_STATUS: led_low[STATUS_W-1:0] = pack_status(err_q, flag_q);
      LED_MODE_PWM:    led_low = wb_q & {LED_DATA_W{pwm_on}};
      LED_MODE_TEST:   led_low = '1;
      default:         led_low = '0;
    endcase
  end

  // Register the LED drive so the pins see clean, glitch-free levels
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led <= '0;
    end else begin
      led <= {hb, led_low};
    end
  end

endmodule

// File: doc/board_io_ctrl.md
Name: board_io_ctrl

Overview:
- Parametrised board-level I/O controller for the FPGA top wrapper. It replaces the ad-hoc single-button debounce, heartbeat and raw LED assignment.
- Provides N-channel button debounce with press pulses, a stretched system-reset request (button 0 or soft request), a configurable heartbeat, sticky error/FP-flag capture, and a mode-selected LED display with PWM dimming.
- Sits between board pins, the processor status outputs and the VIO.

Parameters:
- NUM_BTN, 4, number of button channels (>=1; channel 0 is the reset button)
- DEBOUNCE_CYCLES, 1000000, stable cycles required before a debounced level changes (>=2)
- HB_HALF_PERIOD, 50000000, heartbeat toggle interval in cycles (>=2)
- RST_STRETCH, 16, sys_reset_req high time in cycles (>=1)
- NUM_LED, 8, LED count (>=8)
- DATA_W, 32, writeback data width (>=NUM_LED-1)
- PWM_W, 4, brightness/PWM counter width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- btn_raw  in  NUM_BTN  raw asynchronous button pins, active high
- btn_level  out  NUM_BTN  debounced button levels
- btn_press  out  NUM_BTN  one-cycle pulse on each debounced 0->1 transition
- soft_reset_req  in  1  single-cycle reset request (VIO)
- sys_reset_req  out  1  stretched active-high reset request to processor
- mode  in  2  LED display mode
- brightness  in  PWM_W  PWM duty for mode 2
- wb_valid  in  1  writeback data qualifier
- wb_data  in  DATA_W  integer writeback data
- fp_flags  in  5  FP exception flags (pulses)
- err_int  in  1  integer unrecognised-instruction pulse
- err_fp  in  1  FP unrecognised-instruction pulse
- err_clear  in  1  clears sticky error/flag state
- led  out  NUM_LED  LED drive, registered

Behaviour:
- Reset (reset=0, async): all counters, registers and outputs go to 0.
- Debounce, per channel:
  - 2-flop synchronizer on btn_raw.
  - Counter increments while sync != btn_level and clears while they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the mismatch still present, btn_level flips and the counter clears.
  - Total latency from a stable raw change to btn_level is DEBOUNCE_CYCLES+2 cycles.
  - A glitch shorter than DEBOUNCE_CYCLES never changes the level.
  - btn_press is high in the same cycle btn_level rises; there is no pulse on fall.
- Reset stretch:
  - A trigger is btn_press[0] or soft_reset_req.
  - sys_reset_req rises the cycle after the trigger and stays high exactly RST_STRETCH cycles.
  - A retrigger while high reloads the full RST_STRETCH count.
  - Simultaneous triggers count as one.
- Heartbeat:
  - Counter runs 0..HB_HALF_PERIOD-1; hb toggles on wrap, giving a period of 2*HB_HALF_PERIOD.
  - While sys_reset_req=1, the counter and hb are held at 0.
- Data capture: wb_q <= wb_data when wb_valid=1; otherwise holds.
- Sticky state:
  - err_q[1:0] |= {err_fp, err_int}; flag_q[4:0] |= fp_flags.
  - err_clear zeroes both. A set arriving in the same cycle as err_clear wins: the bit ends up set.
- PWM:
  - Free-running PWM_W-bit counter wraps to 0 after all-ones.
  - pwm_on = (pwm_cnt < brightness), or 1 when brightness is all-ones (full on). brightness=0 gives always off.
- LED (registered, one cycle after sources):
  - led[NUM_LED-1] = hb in every mode.
  - Lower NUM_LED-1 bits by mode:
    - 0: wb_q[NUM_LED-2:0]
    - 1: {zero pad, err_q, flag_q}; flag_q in bits 4:0, err_q in bits 6:5
    - 2: wb_q[NUM_LED-2:0] ANDed with pwm_on
    - 3: all ones (lamp test)
  - A mode change takes effect on the next led update (1 cycle).

Decomposition:
- Package board_io_pkg holds:
  - Mode constants LED_MODE_DATA=0, LED_MODE_STATUS=1, LED_MODE_PWM=2, LED_MODE_TEST=3.
  - FP flag count constant 5.
  - Error bit indices ERR_INT=0, ERR_FP=1.
- One sub-module, btn_debounce: synchronizer plus counter for one channel, parameter DEBOUNCE_CYCLES. It is instantiated NUM_BTN times via generate.
- Stretch, heartbeat, sticky, PWM and LED mux live in board_io_ctrl.

Test Plan (DEBOUNCE_CYCLES=4, HB_HALF_PERIOD=10, RST_STRETCH=3, PWM_W=2, NUM_BTN=2):
- btn_raw[1] held 1 from cycle 0 -> btn_level[1]=1 and btn_press[1]=1 at cycle 6 (DEBOUNCE_CYCLES+2); a 3-cycle pulse on btn_raw[1] -> no level change.
- soft_reset_req pulse at cycle 5 -> sys_reset_req high cycles 6-8. A second pulse at cycle 7 -> high through cycle 10. The heartbeat counter is held at 0 throughout.
- No reset activity -> hb toggles at cycles 10, 20, 30; led[7] follows one cycle later.
- mode=0, wb_valid=1 with wb_data=0x0000_00A5 -> led[6:0]=0x25. Then wb_valid=0 with wb_data=0xFF -> led unchanged.
- mode=1, err_fp pulse, fp_flags=5'b00101 pulse -> led[6:0]=7'b1000101. err_clear coincident with err_int -> err_q=2'b01, flag_q=0.
- mode=2, wb_q low bits all ones, brightness=1 -> each lower LED on 1 of every 4 cycles; brightness=3 -> constantly on; brightness=0 -> off. mode=3 -> led[6:0]=7'h7F. Async reset asserted mid-run -> all outputs 0 immediately.
